rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the single write port of register_file between NREQ writeback requesters, for example the ALU, the load unit and the mult/div unit. Grants one requester per cycle using round-robin priority and drives the registered r_write, rd_addr and rd_w_data signals. It also holds a per-register pending-write scoreboard that the issue stage reserves and queries, so dependent instructions stall until their source is written.

Parameters:
ADDR, 5, register address width; there are 2**ADDR registers.
BUS_W, 32, register data width.
NREQ, 3, number of writeback requesters; must be at least 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  NREQ  per-requester writeback request.
req_addr  input  NREQ*ADDR  packed destination addresses; requester i occupies bits [i*ADDR +: ADDR].
req_data  input  NREQ*BUS_W  packed write data; requester i occupies bits [i*BUS_W +: BUS_W].
req_ready  output  NREQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high.
rsv_valid  input  1  issue stage reserves a destination register.
rsv_addr  input  ADDR  register being reserved.
rs_q_addr  input  ADDR  source-operand query address.
rt_q_addr  input  ADDR  source-operand query address.
rs_busy  output  1  rs_q_addr has a pending write.
rt_busy  output  1  rt_q_addr has a pending write.
r_write  output  1  register_file write enable.
rd_addr  output  ADDR  register_file write address.
rd_w_data  output  BUS_W  register_file write data.
pending  output  1  OR of all scoreboard bits.

Behaviour:
- Reset (asynchronous, immediate) clears the following:
  - r_write=0, rd_addr=0, rd_w_data=0.
  - Scoreboard all 0, so pending=0.
  - Round-robin pointer = 0.
- req_ready is forced to 0 while rst is high.
- Arbitration is combinational within the cycle:
  - Search from the pointer upward, modulo NREQ; the first requester with req_valid high gets req_ready high.
  - At most one req_ready bit is high.
  - req_ready never depends on any other requester's ready.
- Pointer update at the clock edge:
  - On a grant to requester g, the pointer becomes (g+1) mod NREQ.
  - With no grant, the pointer is unchanged.
- Requester rules: req_addr and req_data stay stable while req_valid is high and req_ready is low. A requester may not drop req_valid before it is granted.
- Output stage, one register:
  - A transfer in cycle T gives r_write=1 in cycle T+1, with the captured rd_addr and rd_w_data.
  - If the captured address is 0, r_write stays 0; the request is still consumed and rd_addr/rd_w_data still update.
  - With no transfer, r_write=0 and rd_addr/rd_w_data hold their previous values.
- Register_file commits the write at the end of cycle T+1.
- Scoreboard, 2**ADDR bits; busy[0] is hard-wired to 0:
  - Set: rsv_valid with rsv_addr≠0 sets busy[rsv_addr] at the edge.
  - Clear: r_write=1 clears busy[rd_addr] at the same edge as the register_file commit. A query in T+2 therefore sees not-busy together with the new data.
  - Simultaneous set and clear on the same address: set wins, because a new pending write supersedes the old one.
  - Writes to a register that is not busy are legal and leave the bit at 0.
- rs_busy = busy[rs_q_addr] and rt_busy = busy[rt_q_addr], both combinational with no bypass. An address of 0 always returns 0.
- Throughput is one write per cycle. Each requester waits at most NREQ-1 cycles while it keeps req_valid asserted.
- Reset mid-operation: in-flight captured writes are discarded and r_write drops immediately.

Decomposition:
- Package rf_pkg holds:
  - localparams RF_ADDR=5, RF_BUS_W=32, RF_NREGS=32.
  - typedef rf_addr_t = logic [RF_ADDR-1:0].
  - typedef rf_data_t = logic [RF_BUS_W-1:0].
  - typedef struct packed wb_req_t {addr, data}.
- One sub-module, rr_arbiter (parameter N), contains:
  - inputs clk, rst, req[N];
  - output gnt[N] (one-hot);
  - the internal pointer, advanced when any gnt bit is high.
- Everything else stays in rf_wb_arbiter.

Test Plan:
1. Reset: assert rst mid-cycle with req_valid=3'b111 → outputs immediately 0, req_ready=0, pending=0; after release the first grant goes to requester 0.
2. Round-robin: hold req_valid=3'b111 with distinct addresses 1, 2, 3 for 6 cycles → grants go 0,1,2,0,1,2; r_write=1 on each following cycle with rd_addr 1,2,3,1,2,3.
3. Skip idle requester: req_valid=3'b101 with the pointer at 1 → requester 2 is granted, then requester 0, and the pointer wraps correctly.
4. Scoreboard: reserve addr 7, then requester 1 writes addr 7 with data 0xDEADBEEF → rs_busy=1 for rs_q_addr=7 until r_write edge T+1; from T+2 rs_busy=0 and register_file reads 0xDEADBEEF.
5. Collision: in the cycle r_write clears addr 9, rsv_valid also reserves addr 9 → busy[9] remains 1 and pending=1.
6. Zero register: a requester writes addr 0 with data 0x1234 → the request is consumed, r_write stays 0; rsv_addr=0 leaves pending=0, and querying addr 0 returns rs_busy=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default sizes for the register-file writeback path.
package rf_pkg;

    localparam int unsigned RF_ADDR  = 5;
    localparam int unsigned RF_BUS_W = 32;
    localparam int unsigned RF_NREGS = 32;

    typedef logic [RF_ADDR-1:0]  rf_addr_t;
    typedef logic [RF_BUS_W-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] gnt_idx;
    logic          any_gnt;
    int unsigned   idx;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        any_gnt = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_gnt && req[PW'(idx)]) begin
                gnt[PW'(idx)] = 1'b1;
                gnt_idx       = PW'(idx);
                any_gnt       = 1'b1;
            end
        end
        if (rst) begin
            gnt     = '0;
            any_gnt = 1'b0;
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (any_gnt) begin
            ptr_next = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register_file write port among NREQ writeback requesters and
// tracks pending destination writes for the issue stage.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned ADDR  = RF_ADDR,
    parameter int unsigned BUS_W = RF_BUS_W,
    parameter int unsigned NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ADDR-1:0]  req_addr,
    input  logic [NREQ*BUS_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  rsv_valid,
    input  logic [ADDR-1:0]       rsv_addr,
    input  logic [ADDR-1:0]       rs_q_addr,
    input  logic [ADDR-1:0]       rt_q_addr,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic                  r_write,
    output logic [ADDR-1:0]       rd_addr,
    output logic [BUS_W-1:0]      rd_w_data,
    output logic                  pending
);

    localparam int unsigned NREGS = 1 << ADDR;

    logic [ADDR-1:0]  sel_addr;
    logic [BUS_W-1:0] sel_data;
    logic             xfer;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (req_ready)
    );

    // Payload of the granted requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR +: ADDR];
                sel_data = req_data[i*BUS_W +: BUS_W];
            end
        end
    end

    assign xfer = |(req_valid & req_ready);

    // Writes to register 0 are consumed but never enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write   <= 1'b0;
            rd_addr   <= '0;
            rd_w_data <= '0;
        end else if (xfer) begin
            r_write   <= (sel_addr != '0);
            rd_addr   <= sel_addr;
            rd_w_data <= sel_data;
        end else begin
            r_write   <= 1'b0;
        end
    end

    // A reservation overrides a commit to the same register in the same cycle.
    always_comb begin
        busy_next = busy;
        if (r_write) begin
            busy_next[rd_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs_busy = busy[rs_q_addr];
    assign rt_busy = busy[rt_q_addr];
    assign pending = |busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table, directed corner cases, random vs model.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  rs_q_addr;
    logic [4:0]  rt_q_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic        r_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_w_data;
    logic        pending;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rs_q_addr (rs_q_addr),
        .rt_q_addr (rt_q_addr),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy),
        .r_write   (r_write),
        .rd_addr   (rd_addr),
        .rd_w_data (rd_w_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  ready;
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[11];

    // Reference model state for the random phase
    int          mptr;
    logic        mrw;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic [31:0] mbusy;
    logic [31:0] nbusy;
    wb_req_t     rq[3];
    logic        hold[3];
    int          g;
    logic [2:0]  exp_ready;

    initial begin
        // Round-robin and skip/wrap sequence; requester i writes addr i+1.
        tbl[0]  = '{3'b111, 3'b001, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{3'b111, 3'b010, 1'b1, 5'd1, 32'hA000_0001};
        tbl[2]  = '{3'b111, 3'b100, 1'b1, 5'd2, 32'hA000_0002};
        tbl[3]  = '{3'b111, 3'b001, 1'b1, 5'd3, 32'hA000_0003};
        tbl[4]  = '{3'b111, 3'b010, 1'b1, 5'd1, 32'hA000_0001};
        tbl[5]  = '{3'b111, 3'b100, 1'b1, 5'd2, 32'hA000_0002};
        tbl[6]  = '{3'b001, 3'b001, 1'b1, 5'd3, 32'hA000_0003};
        tbl[7]  = '{3'b101, 3'b100, 1'b1, 5'd1, 32'hA000_0001};
        tbl[8]  = '{3'b101, 3'b001, 1'b1, 5'd3, 32'hA000_0003};
        tbl[9]  = '{3'b000, 3'b000, 1'b1, 5'd1, 32'hA000_0001};
        tbl[10] = '{3'b000, 3'b000, 1'b0, 5'd1, 32'hA000_0001};

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001};
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        rs_q_addr = '0;
        rt_q_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Build up state, then reset mid-cycle with all requesters active.
        req_valid = 3'b111;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        tick();
        rsv_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_r_write", 32'(r_write), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rd_w_data", rd_w_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            req_valid = tbl[i].valid;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_r_write", i), 32'(r_write), 32'(tbl[i].rw));
            chk($sformatf("tbl%0d_rd_addr", i), 32'(rd_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_rd_w_data", i), rd_w_data, tbl[i].data);
            tick();
        end

        // Reserve 7, requester 1 writes it; busy until the commit edge.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        rs_q_addr = 5'd7;
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("sb_busy_set", 32'(rs_busy), 32'd1);
        chk("sb_pending_set", 32'(pending), 32'd1);
        req_valid         = 3'b010;
        req_addr[5 +: 5]  = 5'd7;
        req_data[32 +: 32] = 32'hDEAD_BEEF;
        #1;
        chk("sb_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        #1;
        chk("sb_r_write", 32'(r_write), 32'd1);
        chk("sb_rd_addr", 32'(rd_addr), 32'd7);
        chk("sb_rd_w_data", rd_w_data, 32'hDEAD_BEEF);
        chk("sb_busy_t1", 32'(rs_busy), 32'd1);
        tick();
        chk("sb_busy_t2", 32'(rs_busy), 32'd0);
        chk("sb_pending_t2", 32'(pending), 32'd0);
        chk("sb_r_write_t2", 32'(r_write), 32'd0);

        // Reservation in the same cycle as the commit of addr 9 wins.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        tick();
        rsv_valid           = 1'b0;
        req_valid           = 3'b100;
        req_addr[10 +: 5]   = 5'd9;
        req_data[64 +: 32]  = 32'h55;
        #1;
        chk("col_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        #1;
        chk("col_r_write", 32'(r_write), 32'd1);
        chk("col_rd_addr", 32'(rd_addr), 32'd9);
        tick();
        rsv_valid = 1'b0;
        rs_q_addr = 5'd9;
        #1;
        chk("col_busy", 32'(rs_busy), 32'd1);
        chk("col_pending", 32'(pending), 32'd1);
        req_valid        = 3'b001;
        req_addr[0 +: 5] = 5'd9;
        tick();
        req_valid = '0;
        tick();
        chk("col_cleared", 32'(rs_busy), 32'd0);
        chk("col_pending_clr", 32'(pending), 32'd0);

        // Register 0: consumed, never written, never reserved.
        req_valid          = 3'b010;
        req_addr[5 +: 5]   = 5'd0;
        req_data[32 +: 32] = 32'h1234;
        rsv_valid          = 1'b1;
        rsv_addr           = 5'd0;
        rs_q_addr          = 5'd0;
        #1;
        chk("z_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        rsv_valid = 1'b0;
        #1;
        chk("z_r_write", 32'(r_write), 32'd0);
        chk("z_rd_addr", 32'(rd_addr), 32'd0);
        chk("z_rd_w_data", rd_w_data, 32'h1234);
        chk("z_pending", 32'(pending), 32'd0);
        chk("z_rs_busy", 32'(rs_busy), 32'd0);

        // Random traffic against the reference model, starting from reset.
        rst = 1'b1;
        #2;
        rst   = 1'b0;
        mptr  = 0;
        mrw   = 1'b0;
        maddr = '0;
        mdata = '0;
        mbusy = '0;
        for (int i = 0; i < 3; i++) begin
            hold[i] = 1'b0;
            rq[i]   = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!hold[i] && ($urandom % 2 == 0)) begin
                    rq[i].addr = 5'($urandom_range(0, 15));
                    rq[i].data = $urandom;
                    hold[i]    = 1'b1;
                end
                req_valid[i]            = hold[i];
                req_addr[i*5 +: 5]      = rq[i].addr;
                req_data[i*32 +: 32]    = rq[i].data;
            end
            rsv_valid = ($urandom % 3 == 0);
            rsv_addr  = 5'($urandom_range(0, 15));
            rs_q_addr = 5'($urandom_range(0, 15));
            rt_q_addr = 5'($urandom_range(0, 15));
            #1;
            g = -1;
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && hold[(mptr + k) % 3]) g = (mptr + k) % 3;
            end
            exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_r_write", 32'(r_write), 32'(mrw));
            chk("rnd_rd_addr", 32'(rd_addr), 32'(maddr));
            chk("rnd_rd_w_data", rd_w_data, mdata);
            chk("rnd_rs_busy", 32'(rs_busy), 32'(mbusy[rs_q_addr]));
            chk("rnd_rt_busy", 32'(rt_busy), 32'(mbusy[rt_q_addr]));
            chk("rnd_pending", 32'(pending), 32'(mbusy != '0));
            @(posedge clk);
            nbusy = mbusy;
            if (mrw) nbusy[maddr] = 1'b0;
            if (rsv_valid && rsv_addr != 5'd0) nbusy[rsv_addr] = 1'b1;
            mbusy = nbusy;
            if (g >= 0) begin
                maddr   = rq[g].addr;
                mdata   = rq[g].data;
                mrw     = (rq[g].addr != 5'd0);
                mptr    = (g + 1) % 3;
                hold[g] = 1'b0;
            end else begin
                mrw = 1'b0;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
